// File: rtl/fdiv_seq_ctrl_pkg.sv
// Shared widths, constants, FSM states and field helpers
// for the sequential single-precision divider.
package fdiv_seq_ctrl_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 24;
  localparam int BIAS  = 127;
  localparam int QBITS = 26;

  localparam logic [31:0] QNAN    = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF = 32'h7F80_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_NORM_A,
    S_NORM_B,
    S_DIV,
    S_FIN
  } state_t;

  // {hidden, frac}; hidden is set for any nonzero exponent
  function automatic logic [MAN_W-1:0] mant_of(
    input logic [30:0] x
  );
    return {|x[30:23], x[22:0]};
  endfunction

  // denormals use exponent 1
  function automatic logic [9:0] eexp_of(
    input logic [EXP_W-1:0] ex
  );
    return (ex == '0) ? 10'd1 : {2'b00, ex};
  endfunction

endpackage

// File: rtl/fdiv_seq_ctrl_norm.sv
// 24-bit leading-one normalizer: b = a << move_num,
// ports: a (in), b (out), move_num (out, 0..23).
module fdiv_seq_ctrl_norm
  import fdiv_seq_ctrl_pkg::*;
(
  input  logic [MAN_W-1:0] a,
  output logic [MAN_W-1:0] b,
  output logic [4:0]       move_num
);

  // highest set bit wins; zero input leaves shift at 0
  always_comb begin
    move_num = '0;
    for (int i = 0; i < MAN_W; i++) begin
      if (a[i]) move_num = 5'(MAN_W - 1 - i);
    end
  end

  assign b = a << move_num;

endmodule

// File: rtl/fdiv_seq_ctrl.sv
// Sequential IEEE-754 single divide: normalize, restoring divide, round/pack.
// Ports: clk, rst_n, start/a/b in; ready, done, result, div_by_zero, invalid out.
module fdiv_seq_ctrl
  import fdiv_seq_ctrl_pkg::*;
#(
  parameter int QPC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] result,
  output logic        div_by_zero,
  output logic        invalid
);

  localparam int NCYC = QBITS / QPC;

  state_t state_q, state_d;

  logic [31:0]        a_q, b_q;
  logic [MAN_W-1:0]   ma_q, mb_q;
  logic [4:0]         lza_q;
  logic signed [9:0]  e_q;
  logic [MAN_W:0]     rem_q;
  logic [QBITS-1:0]   quo_q;
  logic [4:0]         cnt_q;
  logic [31:0]        result_q;
  logic               dbz_q, inv_q;

  logic accept, last;

  assign ready  = (state_q == S_IDLE) ||
                  (state_q == S_FIN);
  assign done   = (state_q == S_FIN);
  assign accept = start & ready;
  assign last   = (cnt_q == 5'(NCYC - 1));

  assign result      = result_q;
  assign div_by_zero = dbz_q;
  assign invalid     = inv_q;

  // single normalizer, a in NORM_A and b in NORM_B
  logic [MAN_W-1:0] norm_in, norm_out;
  logic [4:0]       norm_lz;

  assign norm_in = (state_q == S_NORM_B) ?
                   mant_of(b_q[30:0]) :
                   mant_of(a_q[30:0]);

  fdiv_seq_ctrl_norm u_norm (
    .a        (norm_in),
    .b        (norm_out),
    .move_num (norm_lz)
  );

  logic [9:0] e_nx;

  assign e_nx = eexp_of(a_q[30:23])
              - {5'd0, lza_q}
              - eexp_of(b_q[30:23])
              + {5'd0, norm_lz}
              + 10'(BIAS);

  // QPC restoring steps per cycle; the remainder
  // shifts left after each compare
  logic [MAN_W:0]   rem_w, diff_s;
  logic [QBITS-1:0] quo_w;
  logic             ge_s;

  always_comb begin
    rem_w  = rem_q;
    quo_w  = quo_q;
    diff_s = '0;
    ge_s   = 1'b0;
    for (int i = 0; i < QPC; i++) begin
      ge_s   = (rem_w >= {1'b0, mb_q});
      diff_s = ge_s ? rem_w - {1'b0, mb_q} : rem_w;
      rem_w  = diff_s << 1;
      quo_w  = {quo_w[QBITS-2:0], ge_s};
    end
  end

  // round/pack works on the final step's outputs so the
  // result register is valid in the FIN (done) cycle
  logic              hi, g, st, up, carry, sgn;
  logic [22:0]       frac_raw, frac;
  logic signed [9:0] ee;

  always_comb begin
    hi       = quo_w[QBITS-1];
    frac_raw = hi ? quo_w[24:2] : quo_w[23:1];
    g        = hi ? quo_w[1] : quo_w[0];
    st       = (hi & quo_w[0]) | (rem_w != '0);
    up       = g & (st | frac_raw[0]);
    carry    = up & (&frac_raw);
    frac     = frac_raw + 23'(up);
    ee       = hi ? e_q : e_q - 10'sd1;
    if (carry) ee = ee + 10'sd1;
  end

  logic fa_ff, fb_ff, fa_nz, fb_nz;
  logic nan_a, nan_b, inf_a, inf_b;
  logic zero_a, zero_b;

  assign fa_ff  = &a_q[30:23];
  assign fb_ff  = &b_q[30:23];
  assign fa_nz  = |a_q[22:0];
  assign fb_nz  = |b_q[22:0];
  assign nan_a  = fa_ff & fa_nz;
  assign nan_b  = fb_ff & fb_nz;
  assign inf_a  = fa_ff & ~fa_nz;
  assign inf_b  = fb_ff & ~fb_nz;
  assign zero_a = (a_q[30:0] == '0);
  assign zero_b = (b_q[30:0] == '0);
  assign sgn    = a_q[31] ^ b_q[31];

  logic [31:0] pk_res;
  logic        pk_dbz, pk_inv;

  always_comb begin
    pk_res = {sgn, ee[7:0], frac};
    pk_dbz = 1'b0;
    pk_inv = 1'b0;
    if (nan_a | nan_b |
        (zero_a & zero_b) |
        (inf_a & inf_b)) begin
      pk_res = QNAN;
      pk_inv = 1'b1;
    end else if (inf_a) begin
      pk_res = {sgn, POS_INF[30:0]};
    end else if (zero_b) begin
      pk_res = {sgn, POS_INF[30:0]};
      pk_dbz = 1'b1;
    end else if (inf_b | zero_a) begin
      pk_res = {sgn, 31'd0};
    end else if (ee >= 10'sd255) begin
      pk_res = {sgn, POS_INF[30:0]};
    end else if (ee <= 10'sd0) begin
      pk_res = {sgn, 31'd0};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = S_NORM_A;
      S_NORM_A: state_d = S_NORM_B;
      S_NORM_B: state_d = S_DIV;
      S_DIV:    if (last) state_d = S_FIN;
      S_FIN:    state_d = start ? S_NORM_A : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      lza_q    <= '0;
      e_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      inv_q    <= 1'b0;
    end else begin
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
      unique case (state_q)
        S_NORM_A: begin
          ma_q  <= norm_out;
          lza_q <= norm_lz;
        end
        S_NORM_B: begin
          mb_q  <= norm_out;
          e_q   <= $signed(e_nx);
          rem_q <= {1'b0, ma_q};
          quo_q <= '0;
          cnt_q <= '0;
        end
        S_DIV: begin
          rem_q <= rem_w;
          quo_q <= quo_w;
          cnt_q <= cnt_q + 5'd1;
          if (last) begin
            result_q <= pk_res;
            dbz_q    <= pk_dbz;
            inv_q    <= pk_inv;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_seq_ctrl.sv
// Scoreboard bench for fdiv_seq_ctrl, run on a QPC=1 and a QPC=2 instance.
// Expected results are hand-derived IEEE-754 constants.
module tb_fdiv_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_v [2];
  logic [31:0] a_v [2];
  logic [31:0] b_v [2];
  logic        rdy_v [2];
  logic        done_v [2];
  logic [31:0] res_v [2];
  logic        dbz_v [2];
  logic        inv_v [2];

  fdiv_seq_ctrl #(.QPC(1)) u_q1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_v[0]),
    .a           (a_v[0]),
    .b           (b_v[0]),
    .ready       (rdy_v[0]),
    .done        (done_v[0]),
    .result      (res_v[0]),
    .div_by_zero (dbz_v[0]),
    .invalid     (inv_v[0])
  );

  fdiv_seq_ctrl #(.QPC(2)) u_q2 (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start_v[1]),
    .a           (a_v[1]),
    .b           (b_v[1]),
    .ready       (rdy_v[1]),
    .done        (done_v[1]),
    .result      (res_v[1]),
    .div_by_zero (dbz_v[1]),
    .invalid     (inv_v[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        dbz;
    logic        inv;
  } vec_t;

  typedef struct packed {
    logic [31:0] r;
    logic        dbz;
    logic        inv;
  } exp_t;

  vec_t tab [$];
  exp_t sbq [$];

  function automatic int lat_of(input int u);
    return (u == 0) ? 29 : 16;
  endfunction

  task automatic wait_done(input int u, output int n);
    n = 0;
    while (done_v[u] !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic do_op(input int u, input vec_t v);
    int   n;
    exp_t e;
    a_v[u] = v.a;
    b_v[u] = v.b;
    nvec++;
    if (rdy_v[u] !== 1'b1) begin
      nerr++;
      $display("FAIL ready_idle u%0d: got %b want 1",
               u, rdy_v[u]);
    end
    sbq.push_back({v.r, v.dbz, v.inv});
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    start_v[u] = 1'b0;
    wait_done(u, n);
    nvec++;
    if (n !== lat_of(u) - 1) begin
      nerr++;
      $display("FAIL latency u%0d %h/%h: got %0d want %0d",
               u, v.a, v.b, n, lat_of(u) - 1);
    end
    nvec++;
    if (rdy_v[u] !== 1'b1) begin
      nerr++;
      $display("FAIL ready_done u%0d: got %b want 1",
               u, rdy_v[u]);
    end
    nvec++;
    if (sbq.size() == 0) begin
      nerr++;
      $display("FAIL scoreboard_empty u%0d: got none want 1",
               u);
    end else begin
      e = sbq.pop_front();
      if ({res_v[u], dbz_v[u], inv_v[u]} !== e) begin
        nerr++;
        $display("FAIL result u%0d %h/%h: got %h dz%b iv%b want %h dz%b iv%b",
                 u, v.a, v.b, res_v[u], dbz_v[u], inv_v[u],
                 e.r, e.dbz, e.inv);
      end
    end
    @(posedge clk);
    #1;
    nvec++;
    if (done_v[u] !== 1'b0 || res_v[u] !== v.r) begin
      nerr++;
      $display("FAIL pulse_hold u%0d: got done %b res %h want 0 %h",
               u, done_v[u], res_v[u], v.r);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      nvec++;
      if ({rdy_v[u], done_v[u], res_v[u], dbz_v[u], inv_v[u]}
          !== {2'b10, 32'd0, 2'b00}) begin
        nerr++;
        $display("FAIL reset u%0d: got rdy%b done%b res %h dz%b iv%b want 1 0 0 0 0",
                 u, rdy_v[u], done_v[u], res_v[u], dbz_v[u], inv_v[u]);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_vectors(input int u);
    foreach (tab[i]) do_op(u, tab[i]);
  endtask

  task automatic test_busy(input int u);
    int   n;
    int   rdy_bad;
    exp_t e;
    a_v[u] = tab[0].a;
    b_v[u] = tab[0].b;
    sbq.push_back({tab[0].r, tab[0].dbz, tab[0].inv});
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    start_v[u] = 1'b0;
    rdy_bad = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    a_v[u] = tab[1].a;
    b_v[u] = tab[1].b;
    start_v[u] = 1'b1;
    repeat (5) begin
      if (rdy_v[u] !== 1'b0) rdy_bad++;
      @(posedge clk);
      #1;
    end
    start_v[u] = 1'b0;
    nvec++;
    if (rdy_bad != 0) begin
      nerr++;
      $display("FAIL busy_ready u%0d: got %0d high cycles want 0",
               u, rdy_bad);
    end
    wait_done(u, n);
    nvec++;
    if (n >= 200 || sbq.size() == 0) begin
      nerr++;
      $display("FAIL busy_done u%0d: got timeout want done", u);
    end else begin
      e = sbq.pop_front();
      if ({res_v[u], dbz_v[u], inv_v[u]} !== e) begin
        nerr++;
        $display("FAIL busy_result u%0d: got %h want %h",
                 u, res_v[u], e.r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_midreset(input int u);
    int seen;
    a_v[u] = tab[1].a;
    b_v[u] = tab[1].b;
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    start_v[u] = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if ({rdy_v[u], done_v[u], res_v[u]} !== {2'b10, 32'd0}) begin
      nerr++;
      $display("FAIL midreset u%0d: got rdy%b done%b res %h want 1 0 0",
               u, rdy_v[u], done_v[u], res_v[u]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (lat_of(u) + 4) begin
      if (done_v[u] !== 1'b0) seen++;
      @(posedge clk);
      #1;
    end
    nvec++;
    if (seen != 0 || res_v[u] !== 32'd0) begin
      nerr++;
      $display("FAIL midreset_drop u%0d: got %0d dones res %h want 0 0",
               u, seen, res_v[u]);
    end
    do_op(u, tab[2]);
  endtask

  task automatic test_back_to_back(input int u);
    int   n;
    int   tprev;
    int   want;
    exp_t e;
    sbq.push_back({tab[0].r, tab[0].dbz, tab[0].inv});
    sbq.push_back({tab[1].r, tab[1].dbz, tab[1].inv});
    sbq.push_back({tab[7].r, tab[7].dbz, tab[7].inv});
    a_v[u] = tab[0].a;
    b_v[u] = tab[0].b;
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    tprev = cyc;
    a_v[u] = tab[1].a;
    b_v[u] = tab[1].b;
    for (int k = 0; k < 3; k++) begin
      wait_done(u, n);
      want = (k == 0) ? lat_of(u) - 1 : lat_of(u);
      nvec++;
      if (cyc - tprev !== want) begin
        nerr++;
        $display("FAIL b2b_spacing u%0d op%0d: got %0d want %0d",
                 u, k, cyc - tprev, want);
      end
      tprev = cyc;
      nvec++;
      if (sbq.size() == 0) begin
        nerr++;
        $display("FAIL b2b_empty u%0d op%0d: got none want 1", u, k);
      end else begin
        e = sbq.pop_front();
        if ({res_v[u], dbz_v[u], inv_v[u]} !== e) begin
          nerr++;
          $display("FAIL b2b_result u%0d op%0d: got %h want %h",
                   u, k, res_v[u], e.r);
        end
      end
      @(posedge clk);
      #1;
      if (k == 0) begin
        a_v[u] = tab[7].a;
        b_v[u] = tab[7].b;
      end else begin
        start_v[u] = 1'b0;
      end
    end
    nvec++;
    if (done_v[u] !== 1'b0 || rdy_v[u] !== 1'b1) begin
      nerr++;
      $display("FAIL b2b_idle u%0d: got done%b rdy%b want 0 1",
               u, done_v[u], rdy_v[u]);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int u = 0; u < 2; u++) begin
      start_v[u] = 1'b0;
      a_v[u] = '0;
      b_v[u] = '0;
    end
    tab.push_back({32'h40C00000, 32'h40000000, 32'h40400000, 2'b00});
    tab.push_back({32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 2'b00});
    tab.push_back({32'h00000001, 32'h00800000, 32'h34000000, 2'b00});
    tab.push_back({32'h3F800000, 32'h00000000, 32'h7F800000, 2'b10});
    tab.push_back({32'h00000000, 32'h00000000, 32'h7FC00000, 2'b01});
    tab.push_back({32'h7F7FFFFF, 32'h3F000000, 32'h7F800000, 2'b00});
    tab.push_back({32'hBF800000, 32'h40000000, 32'hBF000000, 2'b00});
    tab.push_back({32'h41200000, 32'h40400000, 32'h40555555, 2'b00});
    tab.push_back({32'h3F800000, 32'h40E00000, 32'h3E124925, 2'b00});
    tab.push_back({32'h7F800000, 32'h3F800000, 32'h7F800000, 2'b00});
    tab.push_back({32'h3F800000, 32'h7F800000, 32'h00000000, 2'b00});
    tab.push_back({32'h7FC00000, 32'h3F800000, 32'h7FC00000, 2'b01});
    tab.push_back({32'h7F800000, 32'h7F800000, 32'h7FC00000, 2'b01});
    tab.push_back({32'h00800000, 32'h4B000000, 32'h00000000, 2'b00});
    tab.push_back({32'h80000000, 32'h3F800000, 32'h80000000, 2'b00});
    tab.push_back({32'h3F800000, 32'h80000000, 32'hFF800000, 2'b10});
    tab.push_back({32'h3F800000, 32'h00400000, 32'h7F000000, 2'b00});

    test_reset();
    for (int u = 0; u < 2; u++) begin
      test_vectors(u);
      test_busy(u);
      test_midreset(u);
      test_back_to_back(u);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
